// File: rtl/systolic_sequencer_2x2.sv
// -----------------------------------------------------------------------------
// systolic_sequencer_2x2
//
// Control FSM for the 2x2 weight/input systolic array. A job runs through:
//   IDLE/DONE --start--> LOAD --mem_ready--> [CLEAR] --> FEED x3 --> DRAIN --> DONE
//
// In LOAD it handshakes a memory load. CLEAR is skipped when the job was
// started with accumulate=1, which is used for K-tiling. FEED drives the skewed
// 3-step operand feed. DRAIN waits for the array pipeline to settle, and DONE
// flags c00..c11 as valid. The per-job transpose/activation flags are latched
// with start and held until the next start.
//
// All outputs are registered (Moore). Each transition writes the state
// register and the outputs of the target state in the same clock edge, so the
// outputs always describe the current state.
//
// Handshake: start is a level, sampled only on a rising edge while the state
// is IDLE or DONE; in any other state it is ignored and not queued. mem_ready
// is sampled only on a rising edge while in LOAD, and mem_req stays high for
// every LOAD cycle until that sample is 1. There is no timeout.
//
// Parameters
//   DRAIN_CYCLES  cycles after the last feed step before PE outputs are final (>=1)
//   CNT_W         step counter width, must hold max(2, DRAIN_CYCLES-1)
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   start                     job request
//   accumulate                with start: 1 = keep accumulators (skip CLEAR)
//   transpose_in              with start: transpose input operand
//   activation_in             with start: ReLU enable
//   mem_ready                 memory operands stable (LOAD only)
//   mem_req                   memory request, high only in LOAD
//   clear                     one-cycle accumulator clear
//   data_valid                array feed enable
//   a0_sel/a1_sel             row weight selects (2 = zero)
//   b0_sel/b1_sel             column input selects (2 = zero)
//   transpose, activation     latched job flags
//   busy                      high in LOAD, CLEAR, FEED, DRAIN
//   done                      high in DONE; results valid
// -----------------------------------------------------------------------------
module systolic_sequencer_2x2 #(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       accumulate,
   input  logic       transpose_in,
   input  logic       activation_in,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       clear,
   output logic       data_valid,
   output logic [1:0] a0_sel,
   output logic [1:0] a1_sel,
   output logic [1:0] b0_sel,
   output logic [1:0] b1_sel,
   output logic       transpose,
   output logic       activation,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CLEAR = 3'd2,
      FEED  = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Packed order of all four selects: {a0_sel, a1_sel, b0_sel, b1_sel}.
   localparam logic [7:0] SELS_ZERO = 8'b10_10_10_10;

   localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             acc_job;   // latched accumulate for the running job

   // Skewed feed pattern. Row 1 and column 1 lag row 0 and column 0 by one
   // step, so each PE sees matching k-indices once the array's internal
   // pass-through registers have forwarded the operands.
   //   s=0: 0/2/0/2   s=1: 1/0/1/0   s=2: 2/1/2/1
   function automatic logic [7:0] feed_sels(input logic [CNT_W-1:0] step);
      logic [7:0] sels;
      case (step)
         CNT_W'(0): sels = 8'b00_10_00_10;
         CNT_W'(1): sels = 8'b01_00_01_00;
         default:   sels = 8'b10_01_10_01;
      endcase
      return sels;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         acc_job    <= 1'b0;
         mem_req    <= 1'b0;
         clear      <= 1'b0;
         data_valid <= 1'b0;
         {a0_sel, a1_sel, b0_sel, b1_sel} <= SELS_ZERO;
         transpose  <= 1'b0;
         activation <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         // Single-cycle outputs fall back to idle values unless the target
         // state below drives them.
         clear      <= 1'b0;
         data_valid <= 1'b0;
         {a0_sel, a1_sel, b0_sel, b1_sel} <= SELS_ZERO;

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= LOAD;
                  acc_job    <= accumulate;
                  transpose  <= transpose_in;
                  activation <= activation_in;
                  mem_req    <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
               end
            end

            LOAD: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  if (acc_job) begin
                     state      <= FEED;
                     cnt        <= '0;
                     data_valid <= 1'b1;
                     {a0_sel, a1_sel, b0_sel, b1_sel} <= feed_sels(CNT_W'(0));
                  end else begin
                     state <= CLEAR;
                     clear <= 1'b1;
                  end
               end
            end

            CLEAR: begin
               state      <= FEED;
               cnt        <= '0;
               data_valid <= 1'b1;
               {a0_sel, a1_sel, b0_sel, b1_sel} <= feed_sels(CNT_W'(0));
            end

            FEED: begin
               if (cnt == FEED_LAST) begin
                  state <= DRAIN;
                  cnt   <= '0;
               end else begin
                  cnt        <= cnt + CNT_W'(1);
                  data_valid <= 1'b1;
                  {a0_sel, a1_sel, b0_sel, b1_sel} <= feed_sels(cnt + CNT_W'(1));
               end
            end

            DRAIN: begin
               if (cnt == DRAIN_LAST) begin
                  state <= DONE;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state   <= IDLE;
               cnt     <= '0;
               mem_req <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   // Structural invariants of the output encoding.
   a_clear_xor_feed: assert property (@(posedge clk) disable iff (rst)
      !(clear && data_valid));
   a_mem_req_busy: assert property (@(posedge clk) disable iff (rst)
      mem_req |-> (busy && !clear && !data_valid));
   a_done_not_busy: assert property (@(posedge clk) disable iff (rst)
      !(done && busy));

endmodule

// File: tb/tb_systolic_sequencer_2x2.sv
// -----------------------------------------------------------------------------
// tb_systolic_sequencer_2x2
//
// Drives jobs into the sequencer and checks the output vector against the
// expected state sequence every cycle. A behavioural 2x2 output-stationary
// array is fed by the DUT selects. At done, its results are compared with a
// plain matrix product that was pushed to exp_q when the job started.
// -----------------------------------------------------------------------------
module tb_systolic_sequencer_2x2;

   localparam int DRAIN = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start = 1'b0, accumulate = 1'b0, transpose_in = 1'b0;
   logic       activation_in = 1'b0, mem_ready = 1'b0;
   logic       mem_req, clear, data_valid, transpose, activation, busy, done;
   logic [1:0] a0_sel, a1_sel, b0_sel, b1_sel;

   systolic_sequencer_2x2 #(.DRAIN_CYCLES(DRAIN), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
      .transpose_in(transpose_in), .activation_in(activation_in),
      .mem_ready(mem_ready), .mem_req(mem_req), .clear(clear),
      .data_valid(data_valid), .a0_sel(a0_sel), .a1_sel(a1_sel),
      .b0_sel(b0_sel), .b1_sel(b1_sel), .transpose(transpose),
      .activation(activation), .busy(busy), .done(done)
   );

   // {mem_req, clear, data_valid, a0, a1, b0, b1, busy, done, transpose, activation}
   logic [14:0] obs;
   assign obs = {mem_req, clear, data_valid, a0_sel, a1_sel, b0_sel, b1_sel,
                 busy, done, transpose, activation};

   function automatic logic [14:0] vec(input logic mr, cl, dv, input logic [7:0] sels,
                                       input logic bs, dn, tr, ac);
      return {mr, cl, dv, sels, bs, dn, tr, ac};
   endfunction

   localparam logic [7:0] ZS = 8'hAA;   // all selects = 2

   // ---------------- scoreboard / checking ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack4(input int c0, c1, c2, c3);
      return {16'(c0), 16'(c1), 16'(c2), 16'(c3)};
   endfunction

   // ---------------- memory operands and array model ----------------
   int A[4];   // weight0..3 = A00, A01, A10, A11
   int B[4];   // B00, B01, B10, B11
   int acc_c[4];
   int a0d, a1d, b0d, b1d;
   int av0, av1, bv0, bv1;
   int exp_raw[4];

   function automatic int a_val(input logic [1:0] s, input int x0, input int x1);
      return (s == 2'd0) ? x0 : (s == 2'd1) ? x1 : 0;
   endfunction

   // Column j, select k: element k of column j of the (optionally transposed) input.
   function automatic int b_val(input logic [1:0] s, input int j, input logic t);
      int k;
      if (s > 2'd1) return 0;
      k = int'(s);
      return t ? B[j*2+k] : B[k*2+j];
   endfunction

   always @(negedge clk) begin
      if (rst || clear) begin
         for (int i = 0; i < 4; i++) acc_c[i] = 0;
         a0d = 0; a1d = 0; b0d = 0; b1d = 0;
      end else begin
         av0 = a_val(a0_sel, A[0], A[1]);
         av1 = a_val(a1_sel, A[2], A[3]);
         bv0 = b_val(b0_sel, 0, transpose);
         bv1 = b_val(b1_sel, 1, transpose);
         acc_c[0] += av0 * bv0;
         acc_c[1] += a0d * bv1;
         acc_c[2] += av1 * b0d;
         acc_c[3] += a1d * b1d;
         a0d = av0; a1d = av1; b0d = bv0; b1d = bv1;
      end
   end

   function automatic int relu(input int x, input logic en);
      return (en && x < 0) ? 0 : x;
   endfunction

   // ---------------- driver ----------------
   // Runs one job. ready_lat = LOAD cycles with mem_ready low; poke = pulse
   // start during FEED; abort_cyc != 0 asserts rst in that cycle.
   task automatic run_job(input logic acc, input logic tr, input logic act,
                          input int ready_lat, input logic poke, input int abort_cyc);
      int prod[4];
      int raw[4];
      int n_load, n_clr, t_feed, t_done, s;
      logic [14:0] e;
      logic [63:0] exp_c;

      @(negedge clk);
      start = 1'b1; accumulate = acc; transpose_in = tr; activation_in = act;
      mem_ready = (ready_lat == 0);
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            prod[i*2+j] = 0;
            for (int k = 0; k < 2; k++)
               prod[i*2+j] += A[i*2+k] * (tr ? B[j*2+k] : B[k*2+j]);
         end
      for (int i = 0; i < 4; i++) raw[i] = (acc ? exp_raw[i] : 0) + prod[i];
      if (abort_cyc == 0) begin
         for (int i = 0; i < 4; i++) exp_raw[i] = raw[i];
         exp_q.push_back(pack4(relu(raw[0], act), relu(raw[1], act),
                               relu(raw[2], act), relu(raw[3], act)));
      end

      n_load = ready_lat + 1;
      n_clr  = acc ? 0 : 1;
      t_feed = n_load + n_clr + 1;
      t_done = t_feed + 3 + DRAIN;

      for (int c = 1; c <= t_done + 1; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c <= n_load) mem_ready = (c >= ready_lat + 1);
         else             mem_ready = 1'($urandom_range(1));
         if (poke && c >= t_feed && c < t_feed + 3) start = 1'b1;

         if (c == abort_cyc) begin
            rst = 1'b1;
            #1;
            check($sformatf("abort_c%0d", c), 64'(obs), 64'(vec(0, 0, 0, ZS, 0, 0, 0, 0)));
            @(negedge clk);
            rst = 1'b0;
            return;
         end

         if (c <= n_load)                      e = vec(1, 0, 0, ZS, 1, 0, tr, act);
         else if (n_clr == 1 && c == n_load+1) e = vec(0, 1, 0, ZS, 1, 0, tr, act);
         else if (c < t_feed + 3) begin
            s = c - t_feed;
            e = vec(0, 0, 1, (s == 0) ? 8'h22 : (s == 1) ? 8'h44 : 8'h99, 1, 0, tr, act);
         end
         else if (c < t_done)                  e = vec(0, 0, 0, ZS, 1, 0, tr, act);
         else                                  e = vec(0, 0, 0, ZS, 0, 1, tr, act);
         check($sformatf("cyc_c%0d", c), 64'(obs), 64'(e));

         if (c == t_done) begin
            if (exp_q.size() == 0) begin
               check("sb_empty", 64'd1, 64'd0);
            end else begin
               exp_c = exp_q.pop_front();
               check("result_c", pack4(relu(acc_c[0], activation), relu(acc_c[1], activation),
                                       relu(acc_c[2], activation), relu(acc_c[3], activation)),
                     exp_c);
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic set_ops(input int a0, a1, a2, a3, b0, b1, b2, b3);
      A[0] = a0; A[1] = a1; A[2] = a2; A[3] = a3;
      B[0] = b0; B[1] = b1; B[2] = b2; B[3] = b3;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 4; i++) exp_raw[i] = 0;
      set_ops(1, 2, 3, 4, 5, 6, 7, 8);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_vec", 64'(obs), 64'(vec(0, 0, 0, ZS, 0, 0, 0, 0)));
      rst = 1'b0;

      // IDLE ignores mem_ready
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_hold", 64'(obs), 64'(vec(0, 0, 0, ZS, 0, 0, 0, 0)));

      run_job(0, 0, 0, 0, 0, 0);            // C = [19,22;43,50], done c8
      run_job(1, 0, 0, 0, 0, 0);            // accumulate: [38,44;86,100], done c7
      run_job(0, 1, 0, 0, 0, 0);            // transpose: [17,23;39,53]
      set_ops(-1, -2, -3, -4, 5, 6, 7, 8);
      run_job(0, 0, 1, 0, 0, 0);            // ReLU: all 0
      run_job(0, 0, 0, 0, 0, 0);            // [-19,-22;-43,-50]
      set_ops(1, 2, 3, 4, 5, 6, 7, 8);
      run_job(0, 0, 0, 4, 1, 0);            // slow memory, start pokes in FEED
      run_job(0, 0, 0, 0, 0, 4);            // rst during FEED s=1
      check("post_abort", 64'(obs), 64'(vec(0, 0, 0, ZS, 0, 0, 0, 0)));
      run_job(0, 0, 0, 0, 0, 0);            // full job with clear after abort

      for (int r = 0; r < 4; r++) begin
         set_ops(int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                 int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                 int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8,
                 int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
         run_job(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 int'($urandom_range(3)), 1'($urandom_range(1)), 0);
      end

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
